// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_pkg.sv
// Shared definitions for the TPL ADC capture controller: FSM state
// encodings and the data-width formula used by the top and its interface.
package ad_ip_jesd204_tpl_adc_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_WAIT_SOF = 2'd2,
    ST_CAPTURE  = 2'd3
  } state_t;

  // Width of adc_data for a given lane count and octets per lane per beat.
  function automatic int data_w(input int num_lanes, input int octets_per_beat);
    return num_lanes * 8 * octets_per_beat;
  endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_if.sv
// Datapath bundle between the TPL ADC core / link and the DMA write port.
// The slave side is the capture controller; the master side is the core/DMA.
interface ad_ip_jesd204_tpl_adc_capture_ctrl_if
  import ad_ip_jesd204_tpl_adc_capture_ctrl_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int NUM_CHANNELS    = 4,
  parameter int OCTETS_PER_BEAT = 4
) ();

  localparam int DATA_W = data_w(NUM_LANES, OCTETS_PER_BEAT);

  logic                       link_valid;
  logic [OCTETS_PER_BEAT-1:0] link_sof;
  logic [NUM_CHANNELS-1:0]    in_valid;
  logic [DATA_W-1:0]          in_data;
  logic                       dma_ovf;
  logic [NUM_CHANNELS-1:0]    out_valid;
  logic [DATA_W-1:0]          out_data;

  modport master (
    output link_valid, link_sof, in_valid, in_data, dma_ovf,
    input  out_valid, out_data
  );

  modport slave (
    input  link_valid, link_sof, in_valid, in_data, dma_ovf,
    output out_valid, out_data
  );

endinterface

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl_sync_edge.sv
// ext_sync history register and rising-edge detect. The history resets
// high so a sync line already high at reset is not seen as an edge.
module ad_ip_jesd204_tpl_adc_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic sync_in,
  output logic rise
);

  logic sync_q_reg;

  // Track the previous ext_sync level every cycle, in every state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q_reg <= 1'b1;
    end else begin
      sync_q_reg <= sync_in;
    end
  end

  assign rise = sync_in & ~sync_q_reg;

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Capture sequencer on the TPL ADC output path: arm, wait for a trigger,
// align to a frame start, then pass a programmed number of beats to DMA.
module ad_ip_jesd204_tpl_adc_capture_ctrl
  import ad_ip_jesd204_tpl_adc_capture_ctrl_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int NUM_CHANNELS    = 4,
  parameter int OCTETS_PER_BEAT = 4,
  parameter int LEN_WIDTH       = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    ext_sync_en,
  input  logic                    ext_sync,
  input  logic [LEN_WIDTH-1:0]    capture_len,
  input  logic [NUM_CHANNELS-1:0] chan_enable,
  ad_ip_jesd204_tpl_adc_capture_ctrl_if.slave dp,
  output logic                    sync_status,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf_sticky,
  output logic [LEN_WIDTH-1:0]    beat_count
);

  localparam int DATA_W = data_w(NUM_LANES, OCTETS_PER_BEAT);

  state_t                  state_reg, state_next;
  logic [LEN_WIDTH-1:0]    len_reg;
  logic [LEN_WIDTH-1:0]    beat_count_reg;
  logic                    ovf_reg;
  logic                    done_reg;
  logic [NUM_CHANNELS-1:0] out_valid_reg;
  logic [DATA_W-1:0]       out_data_reg;

  logic sync_rise;
  logic trig;
  logic sof_beat;
  logic arm_accept;
  logic capture_beat;
  logic last_beat;

  ad_ip_jesd204_tpl_adc_sync_edge u_sync_edge (
    .clk     (clk),
    .resetn  (resetn),
    .sync_in (ext_sync),
    .rise    (sync_rise)
  );

  assign trig     = ext_sync_en ? sync_rise : 1'b1;
  assign sof_beat = dp.link_valid & (|dp.link_sof);

  // Next-state and per-cycle strobes; abort overrides everything, including arm.
  always_comb begin
    state_next   = state_reg;
    arm_accept   = 1'b0;
    capture_beat = 1'b0;
    last_beat    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arm) begin
          arm_accept = 1'b1;
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (trig) state_next = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (sof_beat) begin
          capture_beat = 1'b1;
          state_next   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture_beat = dp.link_valid;
      end
      default: state_next = ST_IDLE;
    endcase
    // The first-SOF beat counts like any other, so len=1 finishes on it.
    last_beat = capture_beat && (len_reg != '0) &&
                (beat_count_reg == len_reg - LEN_WIDTH'(1));
    if (last_beat) state_next = ST_IDLE;
    if (abort) begin
      state_next   = ST_IDLE;
      arm_accept   = 1'b0;
      capture_beat = 1'b0;
      last_beat    = 1'b0;
    end
  end

  // State, captured length, saturating beat counter, overflow flag, done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      beat_count_reg <= '0;
      ovf_reg        <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last_beat;
      if (arm_accept) begin
        len_reg        <= capture_len;
        beat_count_reg <= '0;
        ovf_reg        <= 1'b0;
      end else begin
        if (capture_beat && (beat_count_reg != '1))
          beat_count_reg <= beat_count_reg + LEN_WIDTH'(1);
        if (dp.dma_ovf && (state_reg == ST_WAIT_SOF || state_reg == ST_CAPTURE))
          ovf_reg <= 1'b1;
      end
    end
  end

  // Output register stage: valid gated by capture and channel enable, data always.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_reg <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= capture_beat ? (dp.in_valid & chan_enable) : '0;
      out_data_reg  <= dp.in_data;
    end
  end

  assign dp.out_valid  = out_valid_reg;
  assign dp.out_data   = out_data_reg;
  assign sync_status   = (state_reg == ST_ARMED);
  assign busy          = (state_reg != ST_IDLE);
  assign done          = done_reg;
  assign ovf_sticky    = ovf_reg;
  assign beat_count    = beat_count_reg;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture_ctrl.sv
// Directed bench for the TPL ADC capture controller.
module tb_ad_ip_jesd204_tpl_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        arm, abort, ext_sync_en, ext_sync;
  logic [31:0] capture_len;
  logic [3:0]  chan_enable;
  logic        sync_status, busy, done, ovf_sticky;
  logic [31:0] beat_count;

  int n_checks = 0;
  int n_fail   = 0;
  int nv, nd, cnt;

  ad_ip_jesd204_tpl_adc_capture_ctrl_if #(
    .NUM_LANES(1), .NUM_CHANNELS(4), .OCTETS_PER_BEAT(4)
  ) dp_if ();

  ad_ip_jesd204_tpl_adc_capture_ctrl #(
    .NUM_LANES(1), .NUM_CHANNELS(4), .OCTETS_PER_BEAT(4), .LEN_WIDTH(32)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .arm         (arm),
    .abort       (abort),
    .ext_sync_en (ext_sync_en),
    .ext_sync    (ext_sync),
    .capture_len (capture_len),
    .chan_enable (chan_enable),
    .dp          (dp_if),
    .sync_status (sync_status),
    .busy        (busy),
    .done        (done),
    .ovf_sticky  (ovf_sticky),
    .beat_count  (beat_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Stream n link beats; optional SOF, arm and dma_ovf at given beat indices.
  task automatic drive_beats(input int n, input int sof_at, input int arm_at, input int ovf_at,
                             input logic [3:0] ivalid, output int nvalid, output int ndone);
    logic [31:0] d;
    logic [3:0]  exp_mask;
    nvalid   = 0;
    ndone    = 0;
    exp_mask = ivalid & chan_enable;
    for (int i = 0; i < n; i++) begin
      d                  = 32'hA000_0000 + i;
      dp_if.link_valid   = 1'b1;
      dp_if.link_sof     = (i == sof_at) ? 4'b0001 : 4'b0000;
      dp_if.in_valid     = ivalid;
      dp_if.in_data      = d;
      arm                = (i == arm_at);
      dp_if.dma_ovf      = (i == ovf_at);
      cycle();
      if (dp_if.out_valid != 4'b0000) begin
        nvalid++;
        check_eq("beat_valid", 64'(dp_if.out_valid), 64'(exp_mask));
        check_eq("beat_data", 64'(dp_if.out_data), 64'(d));
      end
      if (done) ndone++;
    end
    dp_if.link_valid = 1'b0;
    dp_if.link_sof   = '0;
    dp_if.in_valid   = '0;
    arm              = 1'b0;
    dp_if.dma_ovf    = 1'b0;
  endtask

  task automatic pulse_arm(input logic [31:0] len);
    capture_len = len;
    arm         = 1'b1;
    cycle();
    arm         = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; arm = 1'b0; abort = 1'b0; ext_sync_en = 1'b0; ext_sync = 1'b0;
    capture_len = '0; chan_enable = 4'hF;
    dp_if.link_valid = 1'b0; dp_if.link_sof = '0; dp_if.in_valid = '0;
    dp_if.in_data = '0; dp_if.dma_ovf = 1'b0;
    #23;
    check_eq("rst_out_valid", 64'(dp_if.out_valid), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    check_eq("rst_beat_count", 64'(beat_count), 64'h0);
    check_eq("rst_ovf", 64'(ovf_sticky), 64'h0);
    resetn = 1'b1;
    cycle();

    // 1. Soft trigger, len=4, SOF on the 3rd valid beat after arm.
    pulse_arm(32'd4);
    check_eq("t1_armed_status", 64'(sync_status), 64'h1);
    check_eq("t1_armed_busy", 64'(busy), 64'h1);
    drive_beats(8, 2, -1, -1, 4'hF, nv, nd);
    check_eq("t1_nbeats", 64'(nv), 64'd4);
    check_eq("t1_ndone", 64'(nd), 64'd1);
    check_eq("t1_beat_count", 64'(beat_count), 64'd4);
    check_eq("t1_busy", 64'(busy), 64'h0);

    // 2. External trigger; an edge while idle is ignored.
    ext_sync_en = 1'b1;
    ext_sync = 1'b1;
    cycle();
    check_eq("t2_idle_edge_busy", 64'(busy), 64'h0);
    pulse_arm(32'd2);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      dp_if.link_valid = 1'b1; dp_if.link_sof = 4'b0001; dp_if.in_valid = 4'hF;
      cycle();
      if (dp_if.out_valid != 4'b0000) cnt++;
    end
    dp_if.link_valid = 1'b0; dp_if.link_sof = '0;
    check_eq("t2_hold_no_valid", 64'(cnt), 64'd0);
    check_eq("t2_hold_status", 64'(sync_status), 64'h1);
    ext_sync = 1'b0;
    cycle();
    check_eq("t2_low_status", 64'(sync_status), 64'h1);
    ext_sync = 1'b1;
    cycle();
    check_eq("t2_edge_status", 64'(sync_status), 64'h0);
    check_eq("t2_edge_busy", 64'(busy), 64'h1);
    drive_beats(5, 1, -1, -1, 4'hF, nv, nd);
    check_eq("t2_nbeats", 64'(nv), 64'd2);
    check_eq("t2_ndone", 64'(nd), 64'd1);
    ext_sync_en = 1'b0;

    // 3a. len=1: the SOF beat alone.
    pulse_arm(32'd1);
    drive_beats(4, 1, -1, -1, 4'hF, nv, nd);
    check_eq("t3a_nbeats", 64'(nv), 64'd1);
    check_eq("t3a_ndone", 64'(nd), 64'd1);
    check_eq("t3a_beat_count", 64'(beat_count), 64'd1);

    // 3b. len=0: continuous until abort.
    pulse_arm(32'd0);
    drive_beats(1001, 1, -1, -1, 4'hF, nv, nd);
    check_eq("t3b_nbeats", 64'(nv), 64'd1000);
    check_eq("t3b_ndone", 64'(nd), 64'd0);
    check_eq("t3b_busy", 64'(busy), 64'h1);
    abort = 1'b1; dp_if.link_valid = 1'b1; dp_if.in_valid = 4'hF;
    cycle();
    abort = 1'b0; dp_if.link_valid = 1'b0;
    check_eq("t3b_abort_valid", 64'(dp_if.out_valid), 64'h0);
    check_eq("t3b_abort_busy", 64'(busy), 64'h0);
    check_eq("t3b_abort_done", 64'(done), 64'h0);
    check_eq("t3b_abort_count", 64'(beat_count), 64'd1000);

    // 4. Arm+abort together stays idle; arm during capture is ignored.
    arm = 1'b1; abort = 1'b1; capture_len = 32'd5;
    cycle();
    arm = 1'b0; abort = 1'b0;
    check_eq("t4_armabort_busy", 64'(busy), 64'h0);
    check_eq("t4_armabort_count", 64'(beat_count), 64'd1000);
    pulse_arm(32'd3);
    capture_len = 32'd8;
    drive_beats(8, 1, 2, -1, 4'hF, nv, nd);
    check_eq("t4_nbeats", 64'(nv), 64'd3);
    check_eq("t4_ndone", 64'(nd), 64'd1);
    check_eq("t4_beat_count", 64'(beat_count), 64'd3);
    check_eq("t4_busy", 64'(busy), 64'h0);

    // 5. Channel mask and overflow flag.
    chan_enable = 4'b0101;
    dp_if.dma_ovf = 1'b1;
    cycle();
    dp_if.dma_ovf = 1'b0;
    check_eq("t5_idle_ovf", 64'(ovf_sticky), 64'h0);
    pulse_arm(32'd4);
    drive_beats(8, 1, -1, 3, 4'hF, nv, nd);
    check_eq("t5_nbeats", 64'(nv), 64'd4);
    check_eq("t5_ovf_set", 64'(ovf_sticky), 64'h1);
    cycle();
    check_eq("t5_ovf_held", 64'(ovf_sticky), 64'h1);
    pulse_arm(32'd4);
    check_eq("t5_ovf_cleared", 64'(ovf_sticky), 64'h0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chan_enable = 4'hF;

    // 6. Asynchronous reset mid-capture.
    pulse_arm(32'd10);
    drive_beats(3, 1, -1, 2, 4'hF, nv, nd);
    check_eq("t6_pre_nbeats", 64'(nv), 64'd2);
    dp_if.link_valid = 1'b1; dp_if.in_valid = 4'hF;
    cycle();
    check_eq("t6_pre_valid", 64'(dp_if.out_valid), 64'hF);
    #3 resetn = 1'b0;
    #1;
    check_eq("t6_rst_valid", 64'(dp_if.out_valid), 64'h0);
    check_eq("t6_rst_busy", 64'(busy), 64'h0);
    check_eq("t6_rst_count", 64'(beat_count), 64'h0);
    check_eq("t6_rst_ovf", 64'(ovf_sticky), 64'h0);
    check_eq("t6_rst_data", 64'(dp_if.out_data), 64'h0);
    #2 resetn = 1'b1;
    drive_beats(4, 0, -1, -1, 4'hF, nv, nd);
    check_eq("t6_post_nbeats", 64'(nv), 64'd0);
    check_eq("t6_post_ndone", 64'(nd), 64'd0);
    check_eq("t6_post_busy", 64'(busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
